// File: rtl/x0_align_pipe_pkg.sv
// rtl/x0_align_pipe_pkg.sv - shared widths, complex sample type and parameter checks for the X0 align pipe
//
// Purpose: common helpers for the X0 branch alignment pipeline.
//   out_w()    : output width of the scaled sample (DATA_WIDTH + TWID_WIDTH + 1)
//   shift_ok() : legal full-scale shift range 1..TWID_WIDTH+1
//   cplx_t     : complex sample at the default output width
package x0_align_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 21;
  localparam int TWID_WIDTH_DEF = 16;
  localparam int OUT_W_DEF      = DATA_WIDTH_DEF + TWID_WIDTH_DEF + 1;

  typedef struct packed {
    logic signed [OUT_W_DEF-1:0] re;
    logic signed [OUT_W_DEF-1:0] im;
  } cplx_t;

  function automatic int out_w(input int dw, input int tw);
    return dw + tw + 1;
  endfunction

  // With SHIFT <= TWID_WIDTH+1 the most negative input still fits in out_w bits.
  function automatic bit shift_ok(input int shift, input int tw);
    return (shift >= 1) && (shift <= tw + 1);
  endfunction

endpackage

// File: rtl/x0_align_pipe_if.sv
// rtl/x0_align_pipe_if.sv - valid/ready stream of NCH packed complex lanes with a frame-last tag
//
// Purpose: one beat = NCH complex samples (lane 0 in the LSBs of re/im).
// Signals:
//   valid  beat valid (master -> slave)
//   ready  slave accepts beat (slave -> master)
//   last   last beat of the FFT frame
//   re, im packed signed lane parts, W bits per lane
interface x0_align_pipe_if #(
  parameter int W   = 21,
  parameter int NCH = 1
);
  logic           valid;
  logic           ready;
  logic           last;
  logic [NCH*W-1:0] re;
  logic [NCH*W-1:0] im;

  modport master (output valid, output last, output re, output im, input ready);
  modport slave  (input valid, input last, input re, input im, output ready);
endinterface

// File: rtl/x0_align_pipe_stage.sv
// rtl/x0_align_pipe_stage.sv - one elastic register slice of the X0 align pipe
//
// Purpose: holds one beat (valid, last, NCH-lane payload). Loads from its
//   predecessor whenever i_ready (this stage's ready, computed by the top).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_flush    drop the held beat next edge (payload left stale)
//   i_ready    this stage may load this cycle
//   i_valid, i_last, i_pay   predecessor beat
//   o_valid, o_last, o_pay   registered beat held by this stage
module x0_align_pipe_stage #(
  parameter int PAY_W = 76
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_ready,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [PAY_W-1:0] i_pay,
  output logic             o_valid,
  output logic             o_last,
  output logic [PAY_W-1:0] o_pay
);

  logic             r_valid;
  logic             r_last;
  logic [PAY_W-1:0] r_pay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_pay   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_ready) begin
      r_valid <= i_valid;
      r_last  <= i_last;
      r_pay   <= i_pay;
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_pay   = r_pay;

endmodule

// File: rtl/x0_align_pipe.sv
// rtl/x0_align_pipe.sv - scales the X0 butterfly branch into multiplier Q-format and delays it DEPTH beats
//
// Purpose: b = sign_extend(a) <<< (scale_dn[k] ? SHIFT-1 : SHIFT) per lane,
//   computed on accept, then carried through DEPTH elastic stages so it lines
//   up with the twiddle multiplier output. Outputs are fully registered.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_scale_dn   per-lane /2 stage scaling (shift by SHIFT-1)
//   i_flush      synchronous drop of every in-flight beat and the same-cycle input beat
//   s_in         input stream, DATA_WIDTH bits per lane part
//   m_out        output stream, OUT_W bits per lane part
module x0_align_pipe
  import x0_align_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int SHIFT      = 15,
  parameter int DEPTH      = 2,
  parameter int NCH        = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] i_scale_dn,
  input  logic           i_flush,
  x0_align_pipe_if.slave  s_in,
  x0_align_pipe_if.master m_out
);

  localparam int OUT_W = out_w(DATA_WIDTH, TWID_WIDTH);
  localparam int LW    = NCH * OUT_W;
  localparam int PAY_W = 2 * LW;

  if (!shift_ok(SHIFT, TWID_WIDTH)) begin : g_bad_shift
    $error("x0_align_pipe: SHIFT must lie in 1..TWID_WIDTH+1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("x0_align_pipe: DEPTH must be at least 1");
  end

  function automatic logic [OUT_W-1:0] scale_lane(input logic [DATA_WIDTH-1:0] a,
                                                  input logic dn);
    logic signed [OUT_W-1:0] ext;
    ext = {{(OUT_W-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
    return dn ? (ext <<< (SHIFT-1)) : (ext <<< SHIFT);
  endfunction

  logic [LW-1:0]    w_sh_re;
  logic [LW-1:0]    w_sh_im;
  logic [DEPTH:0]   w_vc;     // w_vc[0] is the input beat, w_vc[i+1] is stage i
  logic [DEPTH:0]   w_lc;
  logic [PAY_W-1:0] w_pay [0:DEPTH];
  logic [DEPTH-1:0] w_ready;

  always_comb begin
    w_sh_re = '0;
    w_sh_im = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sh_re[k*OUT_W +: OUT_W] = scale_lane(s_in.re[k*DATA_WIDTH +: DATA_WIDTH], i_scale_dn[k]);
      w_sh_im[k*OUT_W +: OUT_W] = scale_lane(s_in.im[k*DATA_WIDTH +: DATA_WIDTH], i_scale_dn[k]);
    end
  end

  // ready_i = !v_i | ready_{i+1}, unrolled: stage i may load when any stage
  // from i onward is empty or the consumer takes the output beat. Written
  // without feedback through w_ready so the chain is a flat OR per stage.
  always_comb begin
    logic acc;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = m_out.ready;
      for (int j = i; j < DEPTH; j++) begin
        acc = acc | ~w_vc[j+1];
      end
      w_ready[i] = acc;
    end
  end

  assign w_vc[0]  = s_in.valid;
  assign w_lc[0]  = s_in.last;
  assign w_pay[0] = {w_sh_im, w_sh_re};

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    x0_align_pipe_stage #(
      .PAY_W (PAY_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (i_flush),
      .i_ready (w_ready[g]),
      .i_valid (w_vc[g]),
      .i_last  (w_lc[g]),
      .i_pay   (w_pay[g]),
      .o_valid (w_vc[g+1]),
      .o_last  (w_lc[g+1]),
      .o_pay   (w_pay[g+1])
    );
  end

  assign s_in.ready  = w_ready[0];
  assign m_out.valid = w_vc[DEPTH];
  assign m_out.last  = w_lc[DEPTH];
  assign m_out.re    = w_pay[DEPTH][LW-1:0];
  assign m_out.im    = w_pay[DEPTH][PAY_W-1:LW];

endmodule

// File: tb/tb_x0_align_pipe.sv
// tb/tb_x0_align_pipe.sv - self-checking bench for x0_align_pipe (NCH=4 and NCH=1 instances)
module tb_x0_align_pipe;
  localparam int DW = 21, TW = 16, SHIFT = 15, DEPTH = 2, OW = DW + TW + 1, NL = 4;

  typedef struct packed {
    logic [NL*OW-1:0] re;
    logic [NL*OW-1:0] im;
    logic             last;
    int               cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [NL-1:0] scale;
  always #5 clk = ~clk;

  x0_align_pipe_if #(.W(DW), .NCH(NL)) in4 ();
  x0_align_pipe_if #(.W(OW), .NCH(NL)) out4 ();
  x0_align_pipe_if #(.W(DW), .NCH(1))  in1 ();
  x0_align_pipe_if #(.W(OW), .NCH(1))  out1 ();

  assign in1.valid  = in4.valid;
  assign in1.last   = in4.last;
  assign in1.re     = in4.re[DW-1:0];
  assign in1.im     = in4.im[DW-1:0];
  assign out1.ready = out4.ready;

  x0_align_pipe #(.DATA_WIDTH(DW), .TWID_WIDTH(TW), .SHIFT(SHIFT), .DEPTH(DEPTH), .NCH(NL)) dut4 (
    .clk(clk), .rst(rst), .i_scale_dn(scale), .i_flush(flush), .s_in(in4), .m_out(out4));
  x0_align_pipe #(.DATA_WIDTH(DW), .TWID_WIDTH(TW), .SHIFT(SHIFT), .DEPTH(DEPTH), .NCH(1)) dut1 (
    .clk(clk), .rst(rst), .i_scale_dn(scale[0]), .i_flush(flush), .s_in(in1), .m_out(out1));

  beat_t q[$];
  beat_t cur;
  int n_checks = 0, n_fail = 0, cyc = 0;
  bit chk_lat = 0, last_acc = 0, prev_stall = 0;
  logic [NL*OW-1:0] prev_re, prev_im;
  logic prev_last;

  // Reference: value times 2^shift in plain 64-bit arithmetic.
  function automatic logic [OW-1:0] scale_val(input logic [DW-1:0] a, input bit dn);
    longint v;
    v = longint'($signed(a));
    v = v * (longint'(1) << (dn ? SHIFT - 1 : SHIFT));
    return v[OW-1:0];
  endfunction

  task automatic load_beat(input logic [NL*DW-1:0] ar, input logic [NL*DW-1:0] ai,
                           input logic [NL-1:0] sd, input logic lst);
    in4.re = ar; in4.im = ai; scale = sd; in4.last = lst; in4.valid = 1'b1;
    for (int k = 0; k < NL; k++) begin
      cur.re[k*OW +: OW] = scale_val(ar[k*DW +: DW], sd[k]);
      cur.im[k*OW +: OW] = scale_val(ai[k*DW +: DW], sd[k]);
    end
    cur.last = lst;
  endtask

  task automatic rand_beat(input logic lst);
    logic [NL*DW-1:0] ar, ai;
    for (int k = 0; k < NL; k++) begin
      ar[k*DW +: DW] = DW'($urandom);
      ai[k*DW +: DW] = DW'($urandom);
      if ($urandom_range(0, 7) == 0) ar[k*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
      if ($urandom_range(0, 7) == 0) ai[k*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
    end
    load_beat(ar, ai, NL'($urandom), lst);
  endtask

  // One clock: check against the model at the negedge, update the model, advance.
  task automatic step();
    beat_t e;
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = (q.size() < DEPTH) || (out4.ready === 1'b1);
    n_checks++;
    if (in4.ready !== exp_rdy) begin
      n_fail++; $display("FAIL in_ready4 cyc %0d: got %b expected %b", cyc, in4.ready, exp_rdy);
    end
    n_checks++;
    if (in1.ready !== exp_rdy) begin
      n_fail++; $display("FAIL in_ready1 cyc %0d: got %b expected %b", cyc, in1.ready, exp_rdy);
    end
    n_checks++;
    if (out1.valid !== out4.valid || out4.valid === 1'bx) begin
      n_fail++; $display("FAIL out_valid_lanes cyc %0d: got %b/%b expected equal", cyc, out1.valid, out4.valid);
    end
    if (prev_stall) begin
      n_checks++;
      if (out4.valid !== 1'b1 || out4.re !== prev_re || out4.im !== prev_im || out4.last !== prev_last) begin
        n_fail++; $display("FAIL stall_hold cyc %0d: got v=%b re=%h expected v=1 re=%h", cyc, out4.valid, out4.re, prev_re);
      end
    end
    prev_stall = (out4.valid === 1'b1) && (out4.ready !== 1'b1) && !flush;
    prev_re = out4.re; prev_im = out4.im; prev_last = out4.last;
    if (out4.valid === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++; $display("FAIL spurious_out cyc %0d: got out_valid=1 expected no beat in flight", cyc);
      end else if (out4.ready === 1'b1 && !flush) begin
        e = q.pop_front();
        if (out4.re !== e.re || out4.im !== e.im || out4.last !== e.last) begin
          n_fail++; $display("FAIL out_beat cyc %0d: got re=%h im=%h last=%b expected re=%h im=%h last=%b",
                             cyc, out4.re, out4.im, out4.last, e.re, e.im, e.last);
        end
        n_checks++;
        if (out1.re !== e.re[OW-1:0] || out1.im !== e.im[OW-1:0] || out1.last !== e.last) begin
          n_fail++; $display("FAIL out_beat_nch1 cyc %0d: got re=%h im=%h expected re=%h im=%h",
                             cyc, out1.re, out1.im, e.re[OW-1:0], e.im[OW-1:0]);
        end
        if (chk_lat) begin
          n_checks++;
          if (cyc - e.cyc != DEPTH) begin
            n_fail++; $display("FAIL latency cyc %0d: got %0d expected %0d", cyc, cyc - e.cyc, DEPTH);
          end
        end
      end
    end
    last_acc = (in4.valid === 1'b1) && exp_rdy && !flush;
    if (flush) q.delete();
    else if (last_acc) begin
      cur.cyc = cyc;
      q.push_back(cur);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    in4.valid = 1'b0; flush = 1'b0; out4.ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    step();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout: got %0d beats left expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in4.valid = 1'b0; in4.last = 1'b0; in4.re = '0; in4.im = '0;
    scale = '0; out4.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out4.valid !== 1'b0 || out4.re !== '0 || out4.im !== '0 || out4.last !== 1'b0 || in4.ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_state: got v=%b re=%h im=%h last=%b rdy=%b expected 0,0,0,0,1",
                         out4.valid, out4.re, out4.im, out4.last, in4.ready);
    end
    rst = 1'b0; out4.ready = 1'b0;
    rand_beat(1'b0); step();
    rand_beat(1'b1); step();
    in4.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out4.valid !== 1'b0 || out4.re !== '0 || out4.im !== '0 || out1.valid !== 1'b0 || out4.last !== 1'b0) begin
      n_fail++; $display("FAIL reset_midstream: got v=%b re=%h last=%b expected 0,0,0", out4.valid, out4.re, out4.last);
    end
    q.delete(); prev_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0; out4.ready = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_scaling();
    logic [NL*DW-1:0] ar, ai;
    logic [DW-1:0] tr[3], ti[3];
    logic sd[3];
    longint er[3], ei[3];
    longint x;
    tr = '{DW'(1), DW'(1), {1'b1, {(DW-1){1'b0}}}};
    ti = '{DW'(-1), DW'(-1), {1'b0, {(DW-1){1'b1}}}};
    sd = '{1'b0, 1'b1, 1'b0};
    er = '{32768, 16384, -(longint'(1) << 35)};
    ei = '{-32768, -16384, ((longint'(1) << 20) - 1) * 32768};
    out4.ready = 1'b1; chk_lat = 1;
    for (int i = 0; i < 3; i++) begin
      ar = '0; ai = '0;
      ar[DW-1:0] = tr[i]; ai[DW-1:0] = ti[i];
      load_beat(ar, ai, {3'b000, sd[i]}, 1'b0);
      step();
      in4.valid = 1'b0;
      step();
      x = er[i];
      n_checks++;
      if (out1.valid !== 1'b1 || out1.re !== x[OW-1:0]) begin
        n_fail++; $display("FAIL scale_re case %0d: got v=%b re=%h expected v=1 re=%h", i, out1.valid, out1.re, x[OW-1:0]);
      end
      x = ei[i];
      n_checks++;
      if (out1.im !== x[OW-1:0]) begin
        n_fail++; $display("FAIL scale_im case %0d: got %h expected %h", i, out1.im, x[OW-1:0]);
      end
      step();
    end
    chk_lat = 0;
  endtask

  task automatic test_streaming();
    out4.ready = 1'b1; chk_lat = 1;
    for (int i = 0; i < 16; i++) begin
      rand_beat(i == 15);
      step();
    end
    drain();
    chk_lat = 0;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    bit hold = 0;
    for (int c = 0; c < 60 && sent < 12; c++) begin
      if (!hold) rand_beat(sent == 11);
      out4.ready = !(c >= 4 && c < 9);
      step();
      if (last_acc) begin sent++; hold = 0; end
      else hold = 1;
    end
    n_checks++;
    if (sent != 12) begin
      n_fail++; $display("FAIL backpressure_sent: got %0d expected 12", sent);
    end
    drain();
  endtask

  task automatic test_flush();
    out4.ready = 1'b0;
    rand_beat(1'b0); step();
    rand_beat(1'b1); step();
    rand_beat(1'b0); flush = 1'b1;
    step();
    flush = 1'b0; in4.valid = 1'b0;
    n_checks++;
    if (out4.valid !== 1'b0 || in4.ready !== 1'b1 || out1.valid !== 1'b0) begin
      n_fail++; $display("FAIL flush: got out_valid=%b in_ready=%b expected 0,1", out4.valid, in4.ready);
    end
    out4.ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_lanes();
    logic [NL*DW-1:0] ar, ai;
    logic [OW-1:0] ex;
    for (int k = 0; k < NL; k++) begin
      ar[k*DW +: DW] = DW'(k + 1);
      ai[k*DW +: DW] = DW'(-(k + 1));
    end
    out4.ready = 1'b1;
    load_beat(ar, ai, 4'b1010, 1'b1);
    step();
    in4.valid = 1'b0;
    step();
    for (int k = 0; k < NL; k++) begin
      ex = OW'((k + 1) * ((k % 2 == 1) ? 16384 : 32768));
      n_checks++;
      if (out4.re[k*OW +: OW] !== ex || out4.im[k*OW +: OW] !== OW'(-(k + 1) * ((k % 2 == 1) ? 16384 : 32768))) begin
        n_fail++; $display("FAIL lane_%0d: got re=%h im=%h expected re=%h", k, out4.re[k*OW +: OW], out4.im[k*OW +: OW], ex);
      end
    end
    step();
  endtask

  task automatic test_random();
    bit hold = 0;
    for (int c = 0; c < 80; c++) begin
      if (!hold) begin
        if ($urandom_range(0, 3) != 0) rand_beat(1'($urandom));
        else in4.valid = 1'b0;
      end
      out4.ready = 1'($urandom_range(0, 2) != 0);
      step();
      hold = (in4.valid === 1'b1) && !last_acc;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_scaling();
    test_streaming();
    test_backpressure();
    test_flush();
    test_lanes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

endmodule
